// File: rtl/lsu_align.sv
// lsu_align: byte/half/word load-store alignment with read-modify-write over a word-only data memory
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses through err instead of forcing alignment.
module lsu_align #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_wr,
    input  logic [31:0]       mem_dout
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, ERR, RESP} state_t;
    state_t            state;
    logic [ADDR_W+1:0] a;
    logic [2:0]        f3;
    logic [31:0]       wd, merge, sh, ld_ext, al_addr;
    logic              eflag, is_byte, is_half, is_word, misal, trap, unused_hi;
    logic [4:0]        sft;
    assign is_byte = funct3[1:0] == 2'b00;
    assign is_half = funct3[1:0] == 2'b01;
    assign is_word = !is_byte && !is_half;
    assign misal   = is_half ? addr[0] : (is_word && addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap    = misal;
    assign al_addr = addr;
`else
    assign trap    = 1'b0;
    assign al_addr = {addr[31:2], addr[1] & ~is_word, addr[0] & is_byte};
`endif
    assign unused_hi = ^{al_addr[31:ADDR_W+2], misal};
    assign sft    = {a[1:0], 3'b000};
    assign sh     = mem_dout >> sft;
    assign ld_ext = f3[1:0] == 2'b00 ? {{24{~f3[2] & sh[7]}}, sh[7:0]} :
                    f3[1:0] == 2'b01 ? {{16{~f3[2] & sh[15]}}, sh[15:0]} : mem_dout;
    // Sub-word stores splice the new lane into the word captured in RMW_RD.
    always_comb begin
        mem_din = '0;
        if (state == STORE)
            mem_din = f3[1:0] == 2'b00 ? (merge & ~(32'hFF << sft)) | ({24'b0, wd[7:0]} << sft) :
                      f3[1:0] == 2'b01 ? (merge & ~(32'hFFFF << sft)) | ({16'b0, wd[15:0]} << sft) : wd;
    end
    assign ready    = state == IDLE;
    assign done     = state == RESP;
    assign err      = done && eflag;
    assign mem_wr   = state == STORE && !rst;
    assign mem_addr = state == IDLE ? '0 : a[ADDR_W+1:2];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            f3    <= '0;
            wd    <= '0;
            merge <= '0;
            rdata <= '0;
            eflag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    a     <= al_addr[ADDR_W+1:0];
                    f3    <= funct3;
                    wd    <= wdata;
                    eflag <= trap;
                    state <= trap ? ERR : !we ? LOAD : is_word ? STORE : RMW_RD;
                end
                LOAD: begin
                    rdata <= ld_ext;
                    state <= RESP;
                end
                RMW_RD: begin
                    merge <= mem_dout;
                    state <= STORE;
                end
                STORE, ERR: state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
